// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan sequencer: walks rows and bit planes, kicks the colour
// shifter for each slot and drives a binary-weighted output-enable window.
module hub75_scan_ctrl #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2,
    localparam int rows_p    = vpixel_p / segments_p,
    localparam int row_w     = $clog2(rows_p),
    localparam int addr_w    = $clog2(hpixel_p * vpixel_p),
    localparam int bit_w     = $clog2(bpp_p)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [7:0]        i_base_time,
    input  logic              i_tx_ready,
    output logic              o_tx_start,
    output logic [addr_w-1:0] o_init_addr,
    output logic [bit_w-1:0]  o_pix_bit,
    output logic [row_w-1:0]  o_row_addr,
    output logic              o_oe_n,
    output logic              o_frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        SETTLE,
        DISPLAY,
        NEXT
    } state_e;

    state_e              state_q, state_d;
    logic [row_w-1:0]    row_q, row_d;
    logic [bit_w-1:0]    bit_q, bit_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          base_q, base_d;
    logic                tx_start_q, tx_start_d;
    logic [addr_w-1:0]   init_addr_q, init_addr_d;
    logic [bit_w-1:0]    pix_bit_q, pix_bit_d;
    logic [row_w-1:0]    row_addr_q, row_addr_d;
    logic                oe_n_q, oe_n_d;
    logic                frame_done_q, frame_done_d;

    logic [7:0]          base_eff;
    logic [15:0]         t_len;
    logic                last_bit;
    logic                last_row;

    // A zero base time still gets a one-cycle window so every plane is lit.
    assign base_eff = (base_q == 8'd0) ? 8'd1 : base_q;
    assign t_len    = {8'd0, base_eff} << bit_q;
    assign last_bit = (bit_q == bit_w'(bpp_p - 1));
    assign last_row = (row_q == row_w'(rows_p - 1));

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        bit_d        = bit_q;
        cnt_d        = 16'd0;
        base_d       = base_q;
        init_addr_d  = init_addr_q;
        pix_bit_d    = pix_bit_q;
        row_addr_d   = row_addr_q;
        tx_start_d   = 1'b0;
        oe_n_d       = 1'b1;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable && i_tx_ready) begin
                    state_d = START;
                end
            end
            START: begin
                base_d  = i_base_time;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A shifter that never drops ready missed the pulse; fire it again.
                if (!i_tx_ready) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == 16'd3) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (i_tx_ready) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = DISPLAY;
            end
            DISPLAY: begin
                if (cnt_q >= t_len - 16'd1) begin
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            NEXT: begin
                if (last_bit) begin
                    bit_d = '0;
                    row_d = last_row ? '0 : row_q + row_w'(1);
                end else begin
                    bit_d = bit_q + bit_w'(1);
                end
                if (i_enable && i_tx_ready) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                    if (!i_enable) begin
                        row_d = '0;
                        bit_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        tx_start_d   = (state_d == START);
        oe_n_d       = (state_d != DISPLAY);
        frame_done_d = (state_d == NEXT) && last_bit && last_row;
        if (state_d == START) begin
            init_addr_d = addr_w'(row_d) * addr_w'(hpixel_p);
            pix_bit_d   = bit_d;
        end
        if (state_d == SETTLE) begin
            row_addr_d = row_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            bit_q        <= '0;
            cnt_q        <= 16'd0;
            base_q       <= 8'd0;
            tx_start_q   <= 1'b0;
            init_addr_q  <= '0;
            pix_bit_q    <= '0;
            row_addr_q   <= '0;
            oe_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            tx_start_q   <= tx_start_d;
            init_addr_q  <= init_addr_d;
            pix_bit_q    <= pix_bit_d;
            row_addr_q   <= row_addr_d;
            oe_n_q       <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_init_addr  = init_addr_q;
    assign o_pix_bit    = pix_bit_q;
    assign o_row_addr   = row_addr_q;
    assign o_oe_n       = oe_n_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: a slot-level reference model queues the
// expected start/OE/frame behaviour and a negedge monitor checks each displayed slot.
module tb_hub75_scan_ctrl;

    localparam int H_P    = 4;
    localparam int V_P    = 4;
    localparam int BPP_P  = 2;
    localparam int SEG_P  = 2;
    localparam int ROWS_P = V_P / SEG_P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_enable = 1'b0;
    logic [7:0] i_base_time = 8'd0;
    logic       i_tx_ready = 1'b1;
    logic       o_tx_start;
    logic [3:0] o_init_addr;
    logic       o_pix_bit;
    logic       o_row_addr;
    logic       o_oe_n;
    logic       o_frame_done;

    typedef struct {
        int addr;
        int pbit;
        int width;
        int row;
        int last;
    } slot_t;

    slot_t exp_q[$];
    slot_t mon_e;

    int total = 0;
    int bad = 0;
    int model_row = 0;
    int model_bit = 0;
    bit mon_en = 1'b1;
    bit stuck = 1'b0;
    int busy = 0;
    int slots_done = 0;
    int frames_seen = 0;
    int starts_since = 0;
    int width = 0;
    int disp_row = 0;
    int last_addr = 0;
    int last_pbit = 0;
    bit prev_oe = 1'b1;

    hub75_scan_ctrl #(
        .hpixel_p  (H_P),
        .vpixel_p  (V_P),
        .bpp_p     (BPP_P),
        .segments_p(SEG_P)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_base_time (i_base_time),
        .i_tx_ready  (i_tx_ready),
        .o_tx_start  (o_tx_start),
        .o_init_addr (o_init_addr),
        .o_pix_bit   (o_pix_bit),
        .o_row_addr  (o_row_addr),
        .o_oe_n      (o_oe_n),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, req);
        end
    endtask

    // Colour-shifter stand-in: busy for 10 cycles after each start unless stuck.
    always @(negedge clk) begin
        if (stuck) begin
            i_tx_ready = 1'b1;
            busy = 0;
        end else if (o_tx_start) begin
            i_tx_ready = 1'b0;
            busy = 10;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) i_tx_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_oe = 1'b1;
            width = 0;
            starts_since = 0;
        end else begin
            if (o_tx_start) begin
                starts_since++;
                last_addr = int'(o_init_addr);
                last_pbit = int'(o_pix_bit);
            end
            if (!o_oe_n) begin
                width++;
                if (width == 1) disp_row = int'(o_row_addr);
            end
            if (o_frame_done) frames_seen++;
            if (o_oe_n && !prev_oe) begin
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_slot", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("init_addr", last_addr, mon_e.addr);
                        checkOutput("pix_bit", last_pbit, mon_e.pbit);
                        checkOutput("oe_width", width, mon_e.width);
                        checkOutput("row_addr", disp_row, mon_e.row);
                        checkOutput("frame_done", int'(o_frame_done), mon_e.last);
                        checkOutput("starts_per_slot", starts_since, 1);
                    end
                end
                slots_done++;
                width = 0;
                starts_since = 0;
            end else if (o_frame_done && mon_en) begin
                checkOutput("stray_frame_done", 1, 0);
            end
            prev_oe = o_oe_n;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) (!o_oe_n) |-> $stable(o_row_addr))
        else begin
            bad++;
            $display("[TB] FAIL row_addr_stable: row_addr moved to %0d while oe_n low", o_row_addr);
        end

    assert property (@(posedge clk) disable iff (!rst_n) o_tx_start |=> !o_tx_start)
        else begin
            bad++;
            $display("[TB] FAIL tx_start_pulse: tx_start %0d on consecutive cycles", o_tx_start);
        end

    // Queue n slots from the model, run them, then drop enable during the last one.
    task automatic applyStimulus(input int base, input int n);
        int target;
        int frames0;
        int exp_frames;
        bit ok;
        slot_t s;
        exp_frames = 0;
        for (int i = 0; i < n; i++) begin
            s.addr  = model_row * H_P;
            s.pbit  = model_bit;
            s.width = ((base == 0) ? 1 : base) << model_bit;
            s.row   = model_row;
            s.last  = (model_row == ROWS_P - 1 && model_bit == BPP_P - 1) ? 1 : 0;
            exp_frames += s.last;
            exp_q.push_back(s);
            model_bit++;
            if (model_bit == BPP_P) begin
                model_bit = 0;
                model_row = (model_row + 1) % ROWS_P;
            end
        end
        target  = slots_done + n;
        frames0 = frames_seen;
        i_base_time = base[7:0];
        i_enable = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (slots_done == target - 1 && !o_oe_n) ok = 1'b1;
        end
        if (!ok) checkOutput("reach_last_display", 0, 1);
        i_enable = 1'b0;
        for (int c = 0; c < 3000 && slots_done != target; c++) @(negedge clk);
        checkOutput("slot_count", slots_done, target);
        repeat (6) @(negedge clk);
        checkOutput("idle_oe_n", int'(o_oe_n), 1);
        checkOutput("idle_no_start", starts_since, 0);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("frame_count", frames_seen - frames0, exp_frames);
        exp_q.delete();
        model_row = 0;
        model_bit = 0;
    endtask

    initial begin
        int st[4];
        int n_st;
        bit oe_low;
        bit ok;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_oe_n", int'(o_oe_n), 1);
        checkOutput("rst_tx_start", int'(o_tx_start), 0);
        checkOutput("rst_init_addr", int'(o_init_addr), 0);
        checkOutput("rst_pix_bit", int'(o_pix_bit), 0);
        checkOutput("rst_row_addr", int'(o_row_addr), 0);
        checkOutput("rst_frame_done", int'(o_frame_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(3, 4);
        applyStimulus($urandom_range(1, 5), 8);
        applyStimulus(0, 2);
        applyStimulus(2, 3);
        for (int p = 0; p < 6; p++) applyStimulus($urandom_range(0, 5), $urandom_range(1, 8));

        $display("[TB] stuck-ready retry check");
        mon_en = 1'b0;
        stuck = 1'b1;
        @(negedge clk);
        i_base_time = 8'd2;
        i_enable = 1'b1;
        n_st = 0;
        oe_low = 1'b0;
        for (int c = 0; c < 60 && n_st < 4; c++) begin
            @(negedge clk);
            if (!o_oe_n) oe_low = 1'b1;
            if (o_tx_start) begin
                st[n_st] = c;
                n_st++;
            end
        end
        checkOutput("retry_pulses", n_st, 4);
        for (int k = 1; k < 4; k++) checkOutput("retry_period", st[k] - st[k-1], 5);
        checkOutput("retry_oe_low", int'(oe_low), 0);
        rst_n = 1'b0;
        i_enable = 1'b0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] async reset during display");
        i_base_time = 8'd4;
        i_enable = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (!o_oe_n && o_row_addr == 1'b1 && o_pix_bit == 1'b1) ok = 1'b1;
        end
        checkOutput("reach_row1_bit1", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_oe_n", int'(o_oe_n), 1);
        checkOutput("async_tx_start", int'(o_tx_start), 0);
        checkOutput("async_init_addr", int'(o_init_addr), 0);
        checkOutput("async_pix_bit", int'(o_pix_bit), 0);
        checkOutput("async_row_addr", int'(o_row_addr), 0);
        checkOutput("async_frame_done", int'(o_frame_done), 0);
        i_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_row = 0;
        model_bit = 0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: sim time %0t, limit %0d", $time, 2000000);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameters SHALL be: hpixel_p, 64, display width; vpixel_p, 64, display height; bpp_p, 8, bits per colour channel; segments_p, 2, parallel segments.
REQ-002 Derived constants SHALL be rows_p = vpixel_p/segments_p, row_w = $clog2(rows_p), addr_w = $clog2(hpixel_p*vpixel_p), bit_w = $clog2(bpp_p).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_enable  in  1  scan enable
- i_base_time  in  8  OE-on cycles for bit 0
- i_tx_ready  in  1  colour-shifter idle, connects to its o_ready
- o_tx_start  out  1  shift-start pulse
- o_init_addr  out  addr_w  first pixel address of row
- o_pix_bit  out  bit_w  bit plane being shifted
- o_row_addr  out  row_w  panel row address A..E
- o_oe_n  out  1  panel output enable, active low
- o_frame_done  out  1  end-of-frame pulse

Function
REQ-005 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE, SETTLE, DISPLAY, NEXT; all outputs SHALL be registered.
REQ-006 IDLE: when i_enable=1 and i_tx_ready=1, the FSM SHALL go to START; otherwise it SHALL stay in IDLE with o_oe_n=1.
REQ-007 START: o_tx_start=1 for exactly one cycle; o_init_addr=row*hpixel_p; o_pix_bit=bit; next state WAIT_BUSY.
REQ-008 WAIT_BUSY: o_tx_start=0; on i_tx_ready=0 the FSM SHALL go to WAIT_DONE; if i_tx_ready stays 1 for 4 consecutive cycles, the FSM SHALL return to START (retry).
REQ-009 WAIT_DONE: on i_tx_ready=1 the FSM SHALL go to SETTLE; there is no timeout.
REQ-010 SETTLE (1 cycle): o_row_addr SHALL load the current row; o_oe_n SHALL stay 1.
REQ-011 DISPLAY: o_oe_n SHALL be 0 for exactly T = max(i_base_time,1) << bit cycles, counted by a 16-bit counter; i_base_time SHALL be captured in START.
REQ-012 NEXT (1 cycle, o_oe_n=1): bit SHALL increment; at bit=bpp_p-1, bit SHALL wrap to 0 and row SHALL increment; at row=rows_p-1 with bit=bpp_p-1, row SHALL wrap to 0 and o_frame_done SHALL pulse 1 cycle.
REQ-013 From NEXT, the FSM SHALL go to START if i_enable=1 and i_tx_ready=1, else to IDLE; when entering IDLE because i_enable=0, row and bit SHALL clear to 0.
REQ-014 Deassertion of i_enable mid-sequence SHALL NOT abort the current bit; the sequence SHALL finish through NEXT before going idle.
REQ-015 o_row_addr SHALL change only while o_oe_n=1 (anti-ghosting).
REQ-016 o_oe_n SHALL be 1 in every state except DISPLAY.
REQ-017 Bit order SHALL be LSB first (bit 0..bpp_p-1) within each row; rows SHALL be scanned 0..rows_p-1.

Reset
REQ-018 On rst_n=0, regardless of clk, the block SHALL reset to: state IDLE, row=0, bit=0, o_tx_start=0, o_init_addr=0, o_pix_bit=0, o_row_addr=0, o_oe_n=1, o_frame_done=0, counters 0.
REQ-019 Reset asserted mid-DISPLAY SHALL force o_oe_n=1 asynchronously, and the scan SHALL restart at row 0, bit 0 after release.

Verification
REQ-020 The bench SHALL use hpixel_p=4, vpixel_p=4, bpp_p=2, segments_p=2, and a tx model that drops ready 1 cycle after start and raises it 10 cycles later; it SHALL cover:
- Basic: enable=1, base_time=3 -> start pulses with (init_addr, pix_bit) = (0,0), (0,1), (4,0), (4,1); OE-low widths 3, 6, 3, 6.
- Frame: run 2 frames -> o_frame_done pulses exactly once per 4 bit-slots; row sequence 0,1,0,1.
- base_time=0 -> OE-low widths 1, 2.
- Stuck ready: tx model ignores start -> o_tx_start re-pulses every 5 cycles; o_oe_n stays 1.
- Disable mid-DISPLAY of row 1, bit 0 -> the DISPLAY completes, the FSM goes to IDLE, and on re-enable the first start has init_addr=0, pix_bit=0.
- Async reset mid-DISPLAY -> o_oe_n=1 in the same timestep without a clock edge; all outputs at reset values.
REQ-021 Assertions SHALL check: o_row_addr is stable whenever o_oe_n=0; o_tx_start is never high on 2 consecutive cycles.
